// File: rtl/uart_pkt_pkg.sv
// uart_pkt_pkg
//   Shared definitions for the UART packet controller: header type codes,
//   parser state encoding and the word-FIFO entry layout.
package uart_pkt_pkg;

    // Header byte values that select how the payload is routed
    localparam logic [7:0] LOOPBACK = 8'd0;
    localparam logic [7:0] BOOT     = 8'd1;
    localparam logic [7:0] SCANF    = 8'd3;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        SIZE_LO,
        SIZE_HI,
        PAYLOAD,
        DISCARD
    } state_e;

    // "type" is a reserved word, so the type field is called pkt_type
    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  addr;
        logic [1:0]  pkt_type;
        logic        last;
    } fifo_entry_t;

    function automatic logic hdr_is_valid(input logic [7:0] hdr);
        return (hdr == LOOPBACK) || (hdr == BOOT) || (hdr == SCANF);
    endfunction

endpackage

// File: rtl/uart_pkt_fifo.sv
// uart_pkt_fifo
//   Synchronous word FIFO between the packer and the NoC port.
//   Ports:
//     clk_i, reset_i      clock, synchronous active-high reset
//     push_i, push_data_i write request and entry
//     pop_i               read request (ignored while empty)
//     pop_data_o          head entry, forced to zero while empty
//     full_o, empty_o     occupancy flags
//   A push into a full FIFO is accepted only when a pop happens in the
//   same cycle; otherwise it is silently ignored (the caller flags it).
module uart_pkt_fifo
    import uart_pkt_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        push_i,
    input  fifo_entry_t push_data_i,
    input  logic        pop_i,
    output fifo_entry_t pop_data_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fifo_entry_t   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (!full_o || do_pop);
    assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Storage array carries no reset; the read port is masked while empty
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_pkt_ctrl.sv
// uart_pkt_ctrl
//   Parses framed packets from a UART byte stream
//   (header, NoC address, size low, size high, payload).
//   Loopback packets echo their payload to the UART transmitter through a
//   single-entry register; boot/scanf packets are packed little-endian into
//   32-bit words and queued toward the NoC. Unknown headers are skipped.
//   Ports:
//     sys_clock, reset        clock, synchronous active-high reset
//     rx_data, rx_valid       received bytes, one-cycle strobe, no backpressure
//     tx_data, tx_valid,
//     tx_ready                byte stream to the UART transmitter
//     noc_data/addr/type/last,
//     noc_valid, noc_ready    word stream toward the NoC
//     busy                    packet in progress or output still pending
//     err_header, err_overflow,
//     err_timeout             one-cycle error pulses
//   Build option: define UART_PKT_TIMEOUT_EN to abort a packet after
//   TIMEOUT_CYCLES cycles without a byte; otherwise err_timeout is tied low.
module uart_pkt_ctrl
    import uart_pkt_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic        sys_clock,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] noc_data,
    output logic [7:0]  noc_addr,
    output logic [1:0]  noc_type,
    output logic        noc_last,
    output logic        noc_valid,
    input  logic        noc_ready,
    output logic        busy,
    output logic        err_header,
    output logic        err_overflow,
    output logic        err_timeout
);

    state_e      state_q, state_d;
    logic [7:0]  hdr_q, hdr_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  size_lo_q, size_lo_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] size_full;
    logic [31:0] word_q, word_d, new_word;
    logic [1:0]  idx_q, idx_d;
    logic        push_q, push_d;
    fifo_entry_t push_entry_q, push_entry_d;
    fifo_entry_t pop_entry;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        err_header_q, err_header_d;
    logic        err_overflow_q;
    logic        tx_drop;
    logic        fifo_full, fifo_empty, fifo_pop, fifo_drop;
    logic        timeout_hit;

    // Next-state logic for the parser, the word packer and the TX register.
    // A finished word is staged in push_entry_q for one cycle before it is
    // written to the FIFO, giving the two-cycle byte-to-NoC latency.
    always_comb begin
        state_d      = state_q;
        hdr_d        = hdr_q;
        addr_d       = addr_q;
        size_lo_d    = size_lo_q;
        cnt_d        = cnt_q;
        word_d       = word_q;
        idx_d        = idx_q;
        push_d       = 1'b0;
        push_entry_d = push_entry_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q && !tx_ready;
        err_header_d = 1'b0;
        tx_drop      = 1'b0;
        size_full    = {rx_data, size_lo_q};
        new_word     = word_q;

        case (state_q)
            IDLE: if (rx_valid) begin
                hdr_d   = rx_data;
                state_d = ADDR;
            end
            ADDR: if (rx_valid) begin
                addr_d  = rx_data;
                state_d = SIZE_LO;
            end
            SIZE_LO: if (rx_valid) begin
                size_lo_d = rx_data;
                state_d   = SIZE_HI;
            end
            SIZE_HI: if (rx_valid) begin
                cnt_d  = size_full;
                word_d = '0;
                idx_d  = '0;
                if (size_full == 16'd0) begin
                    state_d = IDLE;
                end else if (hdr_is_valid(hdr_q)) begin
                    state_d = PAYLOAD;
                end else begin
                    state_d      = DISCARD;
                    err_header_d = 1'b1;
                end
            end
            PAYLOAD: if (rx_valid) begin
                cnt_d = cnt_q - 16'd1;
                if (hdr_q == LOOPBACK) begin
                    // Register may be refilled in the cycle its byte leaves
                    if (!tx_valid_q || tx_ready) begin
                        tx_data_d  = rx_data;
                        tx_valid_d = 1'b1;
                    end else begin
                        tx_drop = 1'b1;
                    end
                end else begin
                    new_word[{idx_q, 3'b000} +: 8] = rx_data;
                    if ((idx_q == 2'd3) || (cnt_q == 16'd1)) begin
                        // word_q is cleared after each push, so a partial
                        // final word already has zero upper bytes
                        push_d       = 1'b1;
                        push_entry_d = '{data:     new_word,
                                         addr:     addr_q,
                                         pkt_type: hdr_q[1:0],
                                         last:     (cnt_q == 16'd1)};
                        word_d       = '0;
                        idx_d        = '0;
                    end else begin
                        word_d = new_word;
                        idx_d  = idx_q + 2'd1;
                    end
                end
                if (cnt_q == 16'd1) begin
                    state_d = IDLE;
                end
            end
            DISCARD: if (rx_valid) begin
                cnt_d = cnt_q - 16'd1;
                if (cnt_q == 16'd1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort drops any partially packed word; queued words stay
        if (timeout_hit) begin
            state_d = IDLE;
            word_d  = '0;
            idx_d   = '0;
        end
    end

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            state_q        <= IDLE;
            hdr_q          <= '0;
            addr_q         <= '0;
            size_lo_q      <= '0;
            cnt_q          <= '0;
            word_q         <= '0;
            idx_q          <= '0;
            push_q         <= 1'b0;
            push_entry_q   <= '0;
            tx_data_q      <= '0;
            tx_valid_q     <= 1'b0;
            err_header_q   <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            hdr_q          <= hdr_d;
            addr_q         <= addr_d;
            size_lo_q      <= size_lo_d;
            cnt_q          <= cnt_d;
            word_q         <= word_d;
            idx_q          <= idx_d;
            push_q         <= push_d;
            push_entry_q   <= push_entry_d;
            tx_data_q      <= tx_data_d;
            tx_valid_q     <= tx_valid_d;
            err_header_q   <= err_header_d;
            err_overflow_q <= fifo_drop || tx_drop;
        end
    end

`ifdef UART_PKT_TIMEOUT_EN
    logic [31:0] idle_cnt_q, idle_cnt_d;
    logic        err_timeout_q;

    // Counts consecutive byte-less cycles while a packet is open
    always_comb begin
        idle_cnt_d  = '0;
        timeout_hit = 1'b0;
        if ((state_q != IDLE) && !rx_valid) begin
            if (idle_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                timeout_hit = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            idle_cnt_q    <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            idle_cnt_q    <= idle_cnt_d;
            err_timeout_q <= timeout_hit;
        end
    end

    assign err_timeout = err_timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    assign fifo_pop  = !fifo_empty && noc_ready;
    assign fifo_drop = push_q && fifo_full && !fifo_pop;

    uart_pkt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (sys_clock),
        .reset_i     (reset),
        .push_i      (push_q),
        .push_data_i (push_entry_q),
        .pop_i       (fifo_pop),
        .pop_data_o  (pop_entry),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign noc_valid    = !fifo_empty;
    assign noc_data     = pop_entry.data;
    assign noc_addr     = pop_entry.addr;
    assign noc_type     = pop_entry.pkt_type;
    assign noc_last     = pop_entry.last;
    assign tx_data      = tx_data_q;
    assign tx_valid     = tx_valid_q;
    assign err_header   = err_header_q;
    assign err_overflow = err_overflow_q;
    // push_q covers the staging cycle between the last byte and the FIFO
    assign busy         = (state_q != IDLE) || !fifo_empty || tx_valid_q || push_q;

endmodule
